optic_flow_accumulator_ci: RTL
==============================

# optic_flow_accumulator_ci

Multi-cycle custom instruction directly downstream of the optic-flow custom instruction. Software feeds it the 32-bit flow words that stage returns (8 pixels × {up, down, left, right} bits). It popcounts each direction and accumulates per-frame direction totals. On request it returns individual totals or a saturated net motion vector {net_y, net_x} for the whole frame.

## Interface
- `customInstructionId`, 8'd0, ciN value this block answers to.
- `COUNT_WIDTH`, 20, width of each direction counter (covers 640×480 = 307200 pixels).
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  instruction start strobe, one cycle.
- `ciN`  in  8  instruction id; the block acts only when equal to `customInstructionId`.
- `valueA`  in  32  operand A: flow word (ACCUM) or counter select in [1:0] (READ).
- `valueB`  in  32  opcode in [1:0]; [31:2] ignored.
- `done`  out  1  one-cycle completion pulse, registered.
- `result`  out  32  response; valid only while `done`=1, otherwise 32'd0.

## Operation
- Opcodes in valueB[1:0]: 0 CLEAR, 1 ACCUM, 2 READ, 3 NET.
- Flow word layout, pixel i = 0..7:
  - bit 4i = right
  - bit 4i+1 = left
  - bit 4i+2 = down
  - bit 4i+3 = up
- Four counters cnt_right, cnt_left, cnt_down, cnt_up, each COUNT_WIDTH bits, unsigned. They saturate at all-ones and never wrap.
- **CLEAR:** zero all four counters; result = 0.
- **ACCUM:**
  - Stage 1: 4-bit popcount (0..8) of each direction's 8 bits, registered.
  - Stage 2: each counter += its popcount, saturating.
  - result = {16'd0, up, down, left, right}, each field 4 bits, holding this word's popcounts.
- **READ:** valueA[1:0] selects 0 right, 1 left, 2 down, 3 up. result = zero-extended counter value at the start cycle.
- **NET:**
  - Stage 1: net_x = cnt_right − cnt_left and net_y = cnt_down − cnt_up, both signed COUNT_WIDTH+1 bits.
  - Stage 2: saturate each to signed 16 bits [−32768, 32767].
  - result = {net_y[15:0], net_x[15:0]}.
- FSM states:
  - IDLE
  - ACC (stage 1 of ACCUM)
  - NET (stage 1 of NET)
  - RESP (drive done)
- FSM transitions:
  - IDLE→RESP on CLEAR or READ.
  - IDLE→ACC→RESP on ACCUM.
  - IDLE→NET→RESP on NET.
  - RESP→IDLE always.
- A matching start outside IDLE is ignored: no state change, no extra done. The CPU stalls, so this is a protection only.
- A start with ciN ≠ `customInstructionId` is ignored in every state.
- Reset (any state, mid-operation included): state IDLE, all counters 0, pipeline registers 0, done=0, result=0.

## Timing
- Start sampled high with matching ciN at edge T.
- Latency:
  - CLEAR and READ: done=1 in cycle T+1.
  - ACCUM and NET: done=1 in cycle T+2.
- done is high for exactly one cycle; result is driven from a register only in that cycle.
- Counter update timing:
  - CLEAR takes effect at edge T.
  - ACCUM updates at edge T+1.
- READ and NET issued right after an ACCUM's done observe the updated counters.
- Back-to-back: a new start is accepted in the cycle after done, i.e. in IDLE again.
- Saturation: a counter at 2^COUNT_WIDTH−1 stays there. A partial add that would overflow clamps; it does not wrap.

## Structure
- Shared package `optic_flow_pkg`:
  - opcode constants OP_CLEAR/OP_ACCUM/OP_READ/OP_NET
  - direction index constants DIR_RIGHT/LEFT/DOWN/UP
  - flow-word bit-offset constants, shared with the optic-flow stage so both agree on layout
  - FSM state type
- One sub-module `flow_popcount8`: 8-bit vector in, 4-bit count out, purely combinational. It is instantiated four times.

## Test plan
- Reset mid-ACCUM (drop reset at T+1) -> done never pulses; READ of all counters then returns 0.
- CLEAR, then ACCUM 32'hFFFF_FFFF -> at T+2 done=1, result=32'h0000_8888. READ right/left/down/up each -> 32'd8.
- ACCUM 32'h1111_1111 ×3, then ACCUM 32'h2222_2222 ×1 -> READ right=24, left=8. NET -> 32'h0000_0010.
- Saturation with COUNT_WIDTH=20: 8192 × ACCUM 32'h8888_8888 -> NET returns net_y = −32768, i.e. 32'h8000_0000. With COUNT_WIDTH overridden to 8: 40 × ACCUM 32'h1111_1111 -> READ right=255.
- Protocol: start with wrong ciN -> no done. Second start during ACC -> exactly one done. Result is 0 in every cycle where done=0.
- Back-to-back READ, CLEAR, READ with no idle gap -> first READ returns the old value, second returns 0, one done per instruction.

Source files
------------

// File: rtl/optic_flow_pkg.sv
// ============================================================================
// Module : optic_flow_pkg
// Brief  : Shared opcodes, direction indices, flow-word layout and FSM states
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package optic_flow_pkg;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_ACCUM = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_NET   = 2'd3;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;
  localparam int NUM_DIRS  = 4;

  // Flow-word layout, also used by the upstream optic-flow stage
  localparam int FLOW_PIXELS         = 8;
  localparam int FLOW_BITS_PER_PIXEL = 4;
  localparam int FLOW_OFS_RIGHT      = 0;
  localparam int FLOW_OFS_LEFT       = 1;
  localparam int FLOW_OFS_DOWN       = 2;
  localparam int FLOW_OFS_UP         = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_NET  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic int dir_offset(input int dir);
    case (dir)
      DIR_RIGHT: return FLOW_OFS_RIGHT;
      DIR_LEFT:  return FLOW_OFS_LEFT;
      DIR_DOWN:  return FLOW_OFS_DOWN;
      default:   return FLOW_OFS_UP;
    endcase
  endfunction

  function automatic int flow_bit(input int pixel, input int dir);
    return pixel * FLOW_BITS_PER_PIXEL + dir_offset(dir);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flow_popcount8.sv
// ============================================================================
// Module : flow_popcount8
// Brief  : Combinational population count of an 8-bit vector (0..8)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flow_popcount8 (
  input  logic [7:0] bits_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, bits_i[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/optic_flow_accumulator_ci.sv
// ============================================================================
// Module : optic_flow_accumulator_ci
// Brief  : Per-frame direction totals and saturated net motion custom instr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module optic_flow_accumulator_ci
  import optic_flow_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         COUNT_WIDTH         = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  state_e state_q, state_d;

  logic                   done_q, done_d;
  logic [31:0]            result_q, result_d;
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_DIRS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_DIRS];
  logic [3:0]             pop_q [NUM_DIRS];
  logic [3:0]             pop_d [NUM_DIRS];
  logic signed [COUNT_WIDTH:0] net_x_q, net_x_d;
  logic signed [COUNT_WIDTH:0] net_y_q, net_y_d;

  logic       w_go;
  logic [1:0] w_op;
  logic [3:0] w_pop [NUM_DIRS];
  logic       w_unused_bits;

  assign w_go          = start && (ciN == customInstructionId);
  assign w_op          = valueB[1:0];
  assign w_unused_bits = ^valueB[31:2];

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    logic [7:0] w_bits;
    for (genvar p = 0; p < FLOW_PIXELS; p++) begin : g_pix
      assign w_bits[p] = valueA[flow_bit(p, d)];
    end
    flow_popcount8 u_popcount (
      .bits_i  (w_bits),
      .count_o (w_pop[d])
    );
  end

  function automatic logic [COUNT_WIDTH-1:0] sat_add(
    input logic [COUNT_WIDTH-1:0] c,
    input logic [3:0]             p
  );
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, c} + {{(COUNT_WIDTH-3){1'b0}}, p};
    return s[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : s[COUNT_WIDTH-1:0];
  endfunction

  function automatic logic [15:0] sat16(input logic signed [COUNT_WIDTH:0] v);
    logic signed [31:0] e;
    e = 32'(v);
    if (e > 32'sd32767)       return 16'h7FFF;
    else if (e < -32'sd32768) return 16'h8000;
    else                      return e[15:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Starts are only honoured in IDLE; other states advance unconditionally
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_go) begin
          case (w_op)
            OP_ACCUM: state_d = ST_ACC;
            OP_NET:   state_d = ST_NET;
            default:  state_d = ST_RESP;
          endcase
        end
      end
      ST_ACC:  state_d = ST_RESP;
      ST_NET:  state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done_d   = 1'b0;
    result_d = 32'd0;
    cnt_d    = cnt_q;
    pop_d    = pop_q;
    net_x_d  = net_x_q;
    net_y_d  = net_y_q;
    case (state_q)
      ST_IDLE: begin
        if (w_go) begin
          case (w_op)
            OP_CLEAR: begin
              for (int i = 0; i < NUM_DIRS; i++) cnt_d[i] = '0;
              done_d = 1'b1;
            end
            OP_READ: begin
              done_d   = 1'b1;
              result_d = 32'(cnt_q[valueA[1:0]]);
            end
            OP_ACCUM: pop_d = w_pop;
            default: begin
              net_x_d = $signed({1'b0, cnt_q[DIR_RIGHT]}) - $signed({1'b0, cnt_q[DIR_LEFT]});
              net_y_d = $signed({1'b0, cnt_q[DIR_DOWN]})  - $signed({1'b0, cnt_q[DIR_UP]});
            end
          endcase
        end
      end
      ST_ACC: begin
        for (int i = 0; i < NUM_DIRS; i++) cnt_d[i] = sat_add(cnt_q[i], pop_q[i]);
        done_d   = 1'b1;
        result_d = {16'd0, pop_q[DIR_UP], pop_q[DIR_DOWN], pop_q[DIR_LEFT], pop_q[DIR_RIGHT]};
      end
      ST_NET: begin
        done_d   = 1'b1;
        result_d = {sat16(net_y_q), sat16(net_x_q)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q   <= 1'b0;
      result_q <= 32'd0;
      net_x_q  <= '0;
      net_y_q  <= '0;
      for (int i = 0; i < NUM_DIRS; i++) begin
        cnt_q[i] <= '0;
        pop_q[i] <= 4'd0;
      end
    end else begin
      done_q   <= done_d;
      result_q <= result_d;
      net_x_q  <= net_x_d;
      net_y_q  <= net_y_d;
      cnt_q    <= cnt_d;
      pop_q    <= pop_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire
